sum_lane_scatter: RTL and testbench
===================================

# sum_lane_scatter

Consumer-side partner of the 64-lane segment adder tree. It captures one tree result per accepted valid: the 64-lane 16-bit input vector, the segment sums and the length mode. It holds results in a 2-entry buffer and streams each vector to the downstream normalizer/divider as 8 beats of 8 lanes. Each lane is paired with the segment sum it belongs to. Downstream uses valid/ready backpressure; the upstream tree cannot stall, so overflow is flagged rather than back-pressured.

## Interface
- LANES, 64, lanes per vector (fixed)
- BEAT_LANES, 8, lanes per output beat (fixed; 8 beats per vector)
- W, 16, lane and sum width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; one clock, asynchronous assert, active-low
- i_en  in  1  global enable; when low, all state holds and no handshake completes
- i_valid  in  1  tree result valid (single-cycle pulse)
- i_length_mode  in  4  0 = 64-mode, 1 = 32-mode, 2 = 16-mode; other values are treated as 64-mode
- i_data_flat  in  1024  lane i at [16i +: 16]
- i_sum64_0  in  16  64-mode sum
- i_sum32_0, i_sum32_1  in  16 each  32-mode sums
- i_sum16_0..i_sum16_3  in  16 each  16-mode sums
- o_ready  out  1  at least one buffer entry free (informational)
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts beat
- o_data  out  128  lane 8k+j at [16j +: 16]
- o_sum  out  128  per-lane segment sum, same packing
- o_beat  out  3  beat index k (0..7)
- o_last  out  1  o_beat == 7
- o_mode  out  2  sanitized mode of current vector (0/1/2)
- o_overflow  out  1  sticky: valid arrived with no free entry
- o_mode_err  out  1  sticky: i_length_mode > 2 seen on an accepted valid

## Operation
- Capture condition: i_en & i_valid & (count < 2 or pop_last), where pop_last = o_valid & i_ready & o_last & i_en.
  - On capture, write data, sanitized mode and per-lane sum selection into entry wr_ptr; wr_ptr toggles; count increments.
- Sum selection per lane i:
  - 64-mode: i_sum64_0.
  - 32-mode: i_sum32_(i/32).
  - 16-mode: i_sum16_(i/16).
  - Selection may be stored pre-expanded or as the raw 7 sums plus mode. The output must be identical either way.
- i_en & i_valid with count == 2 and no pop_last: the vector is dropped, o_overflow sets, buffer is unchanged.
- Read side:
  - o_valid = (count > 0); beat counter k is a 3-bit register starting at 0.
  - A beat completes when o_valid & i_ready & i_en.
  - On completion, k increments; on k == 7, k wraps to 0, rd_ptr toggles and count decrements.
- Capture and pop_last in the same cycle: count unchanged, both pointers toggle.
- o_data, o_sum, o_mode and o_beat are driven from entry rd_ptr and must stay stable while o_valid & !i_ready.
- Sticky flags clear only on reset.

## Timing
- Reset (asynchronous, i_rst_n low): count 0, pointers 0, k 0.
  - Outputs: o_valid 0, o_ready 1, o_overflow 0, o_mode_err 0, o_beat 0, o_last 0, o_mode 0, o_data 0, o_sum 0.
  - Buffer contents: don't-care.
- Reset mid-stream discards all buffered vectors; no partial beat survives.
- Latency: a vector captured at edge N presents beat 0 with o_valid = 1 after edge N, provided the buffer was empty.
- Throughput: 1 beat/cycle with i_ready held high. A sustained input rate of 1 vector per 8 cycles never overflows.
- o_ready reflects registered count only (count < 2). Capture may still succeed at count == 2 through pop_last.
- i_en low freezes counters, pointers and flags. Outputs hold their values.

## Test plan
- Reset then idle: o_valid 0, o_ready 1, flags 0; assert i_rst_n low mid-stream, then expect all outputs back at reset values immediately.
- 64-mode capture:
  - Stimulus: lane i = i, sum64 = 0x07E0, i_ready high.
  - Expect: 8 consecutive beats; beat k carries lanes 8k..8k+7; all o_sum lanes 0x07E0; o_last only on beat 7.
- 32-mode and 16-mode mapping:
  - 32-mode, sum32 = {0x0100, 0x0200}: beats 0–3 show 0x0100, beats 4–7 show 0x0200.
  - 16-mode, sums 0x11/0x22/0x33/0x44: each pair of beats shows the matching sum.
- Backpressure:
  - Stimulus: toggle i_ready 1-0-0-1 randomly.
  - Expect: o_data, o_sum and o_beat stable while stalled; no lane lost or duplicated; total 8 handshakes per vector.
- Overflow and boundary:
  - Stimulus: i_ready 0, send 3 valids.
  - Expect: first two buffered, o_overflow 1 after third. Release, and only vectors 1 and 2 emerge, in order.
  - Then send a valid exactly on the beat-7 handshake with count == 2. Expect it accepted and o_overflow not newly set.
- Illegal mode: i_length_mode = 4'd9 with sum64 = 0x0005 → o_mode 0, all sums 0x0005, o_mode_err 1.

Source files
------------

// File: rtl/sum_lane_scatter.sv
// Two-entry result buffer between the segment adder tree and the normalizer.
// Each captured 64-lane vector leaves as 8 beats of 8 lanes with its segment sum alongside.
module sum_lane_scatter #(
  parameter int LANES      = 64,
  parameter int BEAT_LANES = 8,
  parameter int W          = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic                      i_valid,
  input  logic [3:0]                i_length_mode,
  input  logic [LANES*W-1:0]        i_data_flat,
  input  logic [W-1:0]              i_sum64_0,
  input  logic [W-1:0]              i_sum32_0,
  input  logic [W-1:0]              i_sum32_1,
  input  logic [W-1:0]              i_sum16_0,
  input  logic [W-1:0]              i_sum16_1,
  input  logic [W-1:0]              i_sum16_2,
  input  logic [W-1:0]              i_sum16_3,
  output logic                      o_ready,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [BEAT_LANES*W-1:0]   o_data,
  output logic [BEAT_LANES*W-1:0]   o_sum,
  output logic [2:0]                o_beat,
  output logic                      o_last,
  output logic [1:0]                o_mode,
  output logic                      o_overflow,
  output logic                      o_mode_err
);

  localparam int BEATS  = LANES / BEAT_LANES;
  localparam int BW     = BEAT_LANES * W;
  localparam int NSUMS  = 7;

  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [2:0]        beat_q, beat_d;
  logic              ovf_q, ovf_d;
  logic              merr_q, merr_d;

  // Raw sums are kept per entry; per-lane selection happens on the read side.
  logic [LANES*W-1:0] buf_data_q [2];
  logic [NSUMS*W-1:0] buf_sums_q [2];
  logic [1:0]         buf_mode_q [2];

  logic [NSUMS*W-1:0] buf_sums_d;
  logic [1:0]         mode_san;
  logic               rd_valid;
  logic               pop;
  logic               pop_last;
  logic               cap;
  logic               drop;

  always_comb begin
    mode_san = 2'd0;
    if (i_length_mode == 4'd1) begin
      mode_san = 2'd1;
    end else if (i_length_mode == 4'd2) begin
      mode_san = 2'd2;
    end
    buf_sums_d = {i_sum16_3, i_sum16_2, i_sum16_1, i_sum16_0,
                  i_sum32_1, i_sum32_0, i_sum64_0};
  end

  always_comb begin
    rd_valid = (count_q != 2'd0);
    pop      = rd_valid & i_ready & i_en;
    pop_last = pop & (beat_q == 3'd7);
    cap      = i_en & i_valid & ((count_q < 2'd2) | pop_last);
    drop     = i_en & i_valid & (count_q == 2'd2) & ~pop_last;
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q ^ cap;
    rd_ptr_d = rd_ptr_q ^ pop_last;
    beat_d   = pop ? beat_q + 3'd1 : beat_q;
    ovf_d    = ovf_q | drop;
    merr_d   = merr_q | (cap & (i_length_mode > 4'd2));
    case ({cap, pop_last})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      beat_q   <= 3'd0;
      ovf_q    <= 1'b0;
      merr_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      ovf_q    <= ovf_d;
      merr_q   <= merr_d;
    end
  end

  // Buffer contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge i_clk) begin
    if (cap) begin
      buf_data_q[wr_ptr_q] <= i_data_flat;
      buf_sums_q[wr_ptr_q] <= buf_sums_d;
      buf_mode_q[wr_ptr_q] <= mode_san;
    end
  end

  logic [BW-1:0]      beat_slices [BEATS];
  logic [W-1:0]       sum_slices  [NSUMS];
  logic [LANES*W-1:0] rd_data;
  logic [NSUMS*W-1:0] rd_sums;
  logic [1:0]         rd_mode;
  logic [2:0]         sum_idx;
  logic [W-1:0]       beat_sum;
  logic [BW-1:0]      sum_rep;

  always_comb begin
    rd_data = buf_data_q[rd_ptr_q];
    rd_sums = buf_sums_q[rd_ptr_q];
    rd_mode = buf_mode_q[rd_ptr_q];
  end

  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beat_slices[gi] = rd_data[gi*BW +: BW];
    end
    for (gi = 0; gi < NSUMS; gi++) begin : g_sum
      assign sum_slices[gi] = rd_sums[gi*W +: W];
    end
    for (gi = 0; gi < BEAT_LANES; gi++) begin : g_rep
      assign sum_rep[gi*W +: W] = beat_sum;
    end
  endgenerate

  // A beat never straddles a 16-lane segment, so one sum covers the whole beat.
  always_comb begin
    sum_idx = 3'd0;
    case (rd_mode)
      2'd1:    sum_idx = 3'd1 + {2'b00, beat_q[2]};
      2'd2:    sum_idx = 3'd3 + {1'b0, beat_q[2:1]};
      default: sum_idx = 3'd0;
    endcase
    beat_sum = sum_slices[sum_idx];
  end

  // Outputs are forced to zero while empty so reset and idle look identical.
  always_comb begin
    o_ready    = (count_q < 2'd2);
    o_valid    = rd_valid;
    o_beat     = beat_q;
    o_last     = (beat_q == 3'd7);
    o_overflow = ovf_q;
    o_mode_err = merr_q;
    o_data     = '0;
    o_sum      = '0;
    o_mode     = 2'd0;
    if (rd_valid) begin
      o_data = beat_slices[beat_q];
      o_sum  = sum_rep;
      o_mode = rd_mode;
    end
  end

endmodule

// File: tb/tb_sum_lane_scatter.sv
// Directed bench for sum_lane_scatter: a scoreboard queue of expected vectors is
// compared beat by beat against the output stream, with flags tracked alongside.
module tb_sum_lane_scatter;

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic           i_en;
  logic           i_valid;
  logic [3:0]     i_length_mode;
  logic [1023:0]  i_data_flat;
  logic [15:0]    i_sum64_0, i_sum32_0, i_sum32_1;
  logic [15:0]    i_sum16_0, i_sum16_1, i_sum16_2, i_sum16_3;
  logic           o_ready, o_valid, i_ready;
  logic [127:0]   o_data, o_sum;
  logic [2:0]     o_beat;
  logic           o_last;
  logic [1:0]     o_mode;
  logic           o_overflow, o_mode_err;

  sum_lane_scatter dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_valid(i_valid),
    .i_length_mode(i_length_mode), .i_data_flat(i_data_flat),
    .i_sum64_0(i_sum64_0), .i_sum32_0(i_sum32_0), .i_sum32_1(i_sum32_1),
    .i_sum16_0(i_sum16_0), .i_sum16_1(i_sum16_1), .i_sum16_2(i_sum16_2),
    .i_sum16_3(i_sum16_3), .o_ready(o_ready), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_sum(o_sum), .o_beat(o_beat),
    .o_last(o_last), .o_mode(o_mode), .o_overflow(o_overflow),
    .o_mode_err(o_mode_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [15:0] base;
    logic [3:0]  mode;
    logic [15:0] s64;
    logic [15:0] s32_0;
    logic [15:0] s32_1;
    logic [15:0] s16_0;
    logic [15:0] s16_1;
    logic [15:0] s16_2;
    logic [15:0] s16_3;
  } vec_t;

  vec_t sb[$];
  int   exp_k;
  bit   exp_ovf;
  bit   exp_merr;
  bit   en_v;
  int   n_checks;
  int   n_fail;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] base, input logic [3:0] mode,
                              input logic [15:0] s64, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d,
                              input logic [15:0] e, input logic [15:0] f);
    vec_t v;
    v.base = base; v.mode = mode; v.s64 = s64; v.s32_0 = a; v.s32_1 = b;
    v.s16_0 = c; v.s16_1 = d; v.s16_2 = e; v.s16_3 = f;
    return v;
  endfunction

  function automatic logic [1:0] san(input logic [3:0] m);
    if (m == 4'd1) return 2'd1;
    if (m == 4'd2) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [15:0] lane_sum(input vec_t v, input int i);
    logic [1:0] m;
    m = san(v.mode);
    if (m == 2'd1) return (i < 32) ? v.s32_0 : v.s32_1;
    if (m == 2'd2) begin
      if (i < 16) return v.s16_0;
      if (i < 32) return v.s16_1;
      if (i < 48) return v.s16_2;
      return v.s16_3;
    end
    return v.s64;
  endfunction

  function automatic logic [127:0] beat_data(input vec_t v, input int k);
    logic [127:0] r;
    for (int j = 0; j < 8; j++) r[16*j +: 16] = v.base + 16'(8*k + j);
    return r;
  endfunction

  function automatic logic [127:0] beat_sum(input vec_t v, input int k);
    logic [127:0] r;
    for (int j = 0; j < 8; j++) r[16*j +: 16] = lane_sum(v, 8*k + j);
    return r;
  endfunction

  task automatic drive_vec(input vec_t v);
    i_valid = 1'b1;
    i_length_mode = v.mode;
    for (int i = 0; i < 64; i++) i_data_flat[16*i +: 16] = v.base + 16'(i);
    i_sum64_0 = v.s64; i_sum32_0 = v.s32_0; i_sum32_1 = v.s32_1;
    i_sum16_0 = v.s16_0; i_sum16_1 = v.s16_1; i_sum16_2 = v.s16_2; i_sum16_3 = v.s16_3;
  endtask

  // One clock: check outputs against the scoreboard, apply inputs, step the model.
  task automatic cycle(input bit rdy, input bit inj, input vec_t v);
    bit has, hs, acc;
    has = (sb.size() > 0);
    i_ready = rdy;
    i_en = en_v;
    check("valid", 128'(o_valid), 128'(has));
    check("ready", 128'(o_ready), 128'(sb.size() < 2));
    check("overflow", 128'(o_overflow), 128'(exp_ovf));
    check("mode_err", 128'(o_mode_err), 128'(exp_merr));
    if (has) begin
      check("data", o_data, beat_data(sb[0], exp_k));
      check("sum", o_sum, beat_sum(sb[0], exp_k));
      check("beat", 128'(o_beat), 128'(exp_k));
      check("last", 128'(o_last), 128'(exp_k == 7));
      check("mode", 128'(o_mode), 128'(san(sb[0].mode)));
    end
    hs = has && rdy && en_v;
    acc = 1'b0;
    if (inj) begin
      drive_vec(v);
      if (en_v) begin
        if (sb.size() < 2 || (hs && exp_k == 7)) acc = 1'b1;
        else exp_ovf = 1'b1;
      end
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    if (hs) begin
      if (exp_k == 7) begin
        $display("vector base=%h mode=%0d delivered", sb[0].base, sb[0].mode);
        void'(sb.pop_front());
        exp_k = 0;
      end else begin
        exp_k++;
      end
    end
    if (acc) begin
      sb.push_back(v);
      if (v.mode > 4'd2) exp_merr = 1'b1;
    end
  endtask

  task automatic drain(input bit rnd, input int budget);
    vec_t z;
    int n;
    z = '0;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, z);
      n++;
    end
    check("drain_done", 128'(sb.size()), 128'(0));
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", 128'(o_valid), 128'(0));
    check("rst_ready", 128'(o_ready), 128'(1));
    check("rst_ovf", 128'(o_overflow), 128'(0));
    check("rst_merr", 128'(o_mode_err), 128'(0));
    check("rst_beat", 128'(o_beat), 128'(0));
    check("rst_last", 128'(o_last), 128'(0));
    check("rst_mode", 128'(o_mode), 128'(0));
    check("rst_data", o_data, 128'(0));
    check("rst_sum", o_sum, 128'(0));
  endtask

  initial begin
    vec_t z, a, b, c;
    int sent, guard;
    z = '0;
    n_checks = 0; n_fail = 0; exp_k = 0; exp_ovf = 0; exp_merr = 0; en_v = 1'b1;
    i_rst_n = 1'b0; i_en = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_length_mode = 4'd0;
    i_data_flat = '0; i_sum64_0 = '0; i_sum32_0 = '0; i_sum32_1 = '0;
    i_sum16_0 = '0; i_sum16_1 = '0; i_sum16_2 = '0; i_sum16_3 = '0;
    #12;
    check_reset_outputs();
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    repeat (3) cycle(1'b1, 1'b0, z);

    // 64-, 32- and 16-mode mapping
    cycle(1'b1, 1'b1, mk(16'h0000, 4'd0, 16'h07E0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
    drain(1'b0, 40);
    cycle(1'b1, 1'b1, mk(16'h1000, 4'd1, 16'hDEAD, 16'h0100, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0));
    drain(1'b0, 40);
    cycle(1'b1, 1'b1, mk(16'h2000, 4'd2, 16'hBEEF, 16'h5555, 16'h6666, 16'h0011, 16'h0022, 16'h0033, 16'h0044));
    drain(1'b0, 40);

    // Overflow: third vector dropped while stalled
    cycle(1'b0, 1'b1, mk(16'h3000, 4'd0, 16'h0A0A, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
    cycle(1'b0, 1'b1, mk(16'h4000, 4'd1, 16'h0, 16'h0B0B, 16'h0C0C, 16'h0, 16'h0, 16'h0, 16'h0));
    cycle(1'b0, 1'b1, mk(16'h5000, 4'd0, 16'h0D0D, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
    repeat (2) cycle(1'b0, 1'b0, z);
    drain(1'b0, 60);

    // Reset mid-stream
    cycle(1'b1, 1'b1, mk(16'h6000, 4'd0, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
    repeat (3) cycle(1'b1, 1'b0, z);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs();
    sb.delete();
    exp_k = 0; exp_ovf = 0; exp_merr = 0;
    i_rst_n = 1'b1;
    cycle(1'b1, 1'b0, z);

    // Capture on the beat-7 handshake while full
    a = mk(16'h7000, 4'd2, 16'h0, 16'h0, 16'h0, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    b = mk(16'h8000, 4'd1, 16'h0, 16'h0505, 16'h0606, 16'h0, 16'h0, 16'h0, 16'h0);
    c = mk(16'h9000, 4'd0, 16'h0707, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    cycle(1'b0, 1'b1, a);
    cycle(1'b0, 1'b1, b);
    repeat (7) cycle(1'b1, 1'b0, z);
    cycle(1'b1, 1'b1, c);
    cycle(1'b0, 1'b0, z);
    drain(1'b0, 60);

    // Illegal mode falls back to 64-mode
    cycle(1'b1, 1'b1, mk(16'hA000, 4'd9, 16'h0005, 16'h0F0F, 16'hF0F0, 16'h1, 16'h2, 16'h3, 16'h4));
    drain(1'b0, 40);

    // Enable low freezes everything, including capture
    cycle(1'b1, 1'b1, mk(16'hB000, 4'd1, 16'h0, 16'h0AAA, 16'h0BBB, 16'h0, 16'h0, 16'h0, 16'h0));
    cycle(1'b1, 1'b0, z);
    en_v = 1'b0;
    cycle(1'b1, 1'b1, mk(16'hC000, 4'd0, 16'h0CCC, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0));
    repeat (3) cycle(1'b1, 1'b0, z);
    en_v = 1'b1;
    drain(1'b0, 40);

    // Random backpressure with vectors arriving while streaming
    sent = 0;
    guard = 0;
    while (sent < 6 && guard < 500) begin
      if (sb.size() < 2 && guard % 5 == 0) begin
        cycle(1'($urandom_range(0, 1)), 1'b1,
              mk(16'hD000 + 16'(sent * 16'h100), 4'(sent % 3), 16'h0E00 + 16'(sent),
                 16'h0E10 + 16'(sent), 16'h0E20 + 16'(sent), 16'h0E30 + 16'(sent),
                 16'h0E40 + 16'(sent), 16'h0E50 + 16'(sent), 16'h0E60 + 16'(sent)));
        sent++;
      end else begin
        cycle(1'($urandom_range(0, 1)), 1'b0, z);
      end
      guard++;
    end
    check("bp_sent", 128'(sent), 128'(6));
    drain(1'b1, 400);
    repeat (2) cycle(1'b1, 1'b0, z);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
